// File: rtl/ifetch_queue.sv
// ifetch_queue: byte-serial instruction fetch unit with a small instruction FIFO.
// Each instruction is assembled from four consecutive little-endian bytes read from
// a single-byte-wide memory that has a one-cycle read latency. A redirect from execute
// flushes all fetch state and restarts fetching at the new target.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to force redirect targets onto word
// boundaries and to flag misaligned redirects on the sticky misalign_err output.
module ifetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        nreset,
    output logic        mem_rd,
    output logic [7:0]  mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        redir_valid,
    input  logic [7:0]  redir_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [7:0]  instr_pc,
    output logic        misalign_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Fetch/issue state
    logic [7:0]  fetch_pc_reg;
    logic        issuing_reg;      // bytes 1..3 of a started instruction still to issue
    logic [1:0]  issue_idx_reg;    // byte index of the next read while issuing
    logic        pending_reg;      // one read outstanding, data arrives this cycle
    logic [1:0]  pend_idx_reg;     // byte index of the outstanding read

    // Assembly state
    logic        asm_active_reg;   // an instruction has been started but not yet pushed
    logic [23:0] asm_data_reg;     // bytes 0..2 collected so far
    logic [7:0]  asm_pc_reg;

    // Instruction FIFO
    logic [31:0]   fifo_data [DEPTH];
    logic [7:0]    fifo_pc   [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic [CW-1:0] occupancy;
    logic          start;
    logic          push;
    logic          pop;
    logic [7:0]    redir_target;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic misalign_reg;
    logic redir_misaligned;
    assign redir_target     = {redir_pc[7:2], 2'b00};
    assign redir_misaligned = (redir_pc[1:0] != 2'b00);
    assign misalign_err     = misalign_reg;

    // Sticky misaligned-redirect flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!nreset) begin
            misalign_reg <= 1'b0;
        end else if (redir_valid && redir_misaligned) begin
            misalign_reg <= 1'b1;
        end
    end
`else
    assign redir_target = redir_pc;
    assign misalign_err = 1'b0;
`endif

    // A new instruction may start only if it will have a FIFO slot waiting for it;
    // the instruction currently being assembled already owns one slot.
    assign occupancy = count_reg + CW'(asm_active_reg);
    assign start     = !issuing_reg && (occupancy < CW'(DEPTH));

    assign mem_rd   = nreset && !redir_valid && (issuing_reg || start);
    assign mem_addr = fetch_pc_reg;

    // Byte 3 arriving completes the word; it goes straight into the FIFO.
    assign push = pending_reg && (pend_idx_reg == 2'd3);

    assign instr_valid = nreset && (count_reg != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr_data  = instr_valid ? fifo_data[rd_ptr_reg] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr_reg]   : 8'h00;

    // Read issue sequencing and byte assembly; redirect discards everything in flight
    always_ff @(posedge clk) begin
        if (!nreset) begin
            fetch_pc_reg   <= RESET_PC;
            issuing_reg    <= 1'b0;
            issue_idx_reg  <= 2'd0;
            pending_reg    <= 1'b0;
            pend_idx_reg   <= 2'd0;
            asm_active_reg <= 1'b0;
            asm_data_reg   <= 24'h0;
            asm_pc_reg     <= 8'h00;
        end else if (redir_valid) begin
            fetch_pc_reg   <= redir_target;
            issuing_reg    <= 1'b0;
            issue_idx_reg  <= 2'd0;
            pending_reg    <= 1'b0;
            asm_active_reg <= 1'b0;
        end else begin
            pending_reg  <= mem_rd;
            pend_idx_reg <= issuing_reg ? issue_idx_reg : 2'd0;

            if (mem_rd) begin
                fetch_pc_reg <= fetch_pc_reg + 8'd1;
                if (issuing_reg) begin
                    issue_idx_reg <= issue_idx_reg + 2'd1;
                    if (issue_idx_reg == 2'd3) begin
                        issuing_reg <= 1'b0;
                    end
                end else begin
                    issuing_reg   <= 1'b1;
                    issue_idx_reg <= 2'd1;
                    asm_pc_reg    <= fetch_pc_reg;
                end
            end

            // A start in the same cycle as a push keeps the assembly busy
            if (mem_rd && !issuing_reg) begin
                asm_active_reg <= 1'b1;
            end else if (push) begin
                asm_active_reg <= 1'b0;
            end

            if (pending_reg) begin
                case (pend_idx_reg)
                    2'd0:    asm_data_reg[7:0]   <= mem_rdata;
                    2'd1:    asm_data_reg[15:8]  <= mem_rdata;
                    2'd2:    asm_data_reg[23:16] <= mem_rdata;
                    default: asm_data_reg        <= asm_data_reg;
                endcase
            end
        end
    end

    // FIFO pointers and occupancy; redirect flushes and overrides push/pop
    always_ff @(posedge clk) begin
        if (!nreset || redir_valid) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage write port (no reset needed; entries are only read when valid)
    always_ff @(posedge clk) begin
        if (nreset && !redir_valid && push) begin
            fifo_data[wr_ptr_reg] <= {mem_rdata, asm_data_reg};
            fifo_pc[wr_ptr_reg]   <= asm_pc_reg;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed testbench for ifetch_queue. Two instances: default RESET_PC and RESET_PC=8'hFC.
// Each instance has a one-cycle-latency byte memory model; bytes 0..7 hold 11..88 and
// every other address holds its own address value.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nreset, redir_valid, instr_ready;
    logic [7:0]  redir_pc;
    logic        mem_rd, instr_valid, misalign_err;
    logic [7:0]  mem_addr, instr_pc;
    logic [7:0]  mem_rdata = 8'h00;
    logic [31:0] instr_data;

    logic        nreset2, instr_ready2;
    logic        mem_rd2, instr_valid2, misalign_err2;
    logic [7:0]  mem_addr2, instr_pc2;
    logic [7:0]  mem_rdata2 = 8'h00;
    logic [31:0] instr_data2;

    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;

    ifetch_queue #(.DEPTH(4), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .nreset(nreset), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_pc(instr_pc), .misalign_err(misalign_err)
    );

    ifetch_queue #(.DEPTH(4), .RESET_PC(8'hFC)) u_dut_fc (
        .clk(clk), .nreset(nreset2), .mem_rd(mem_rd2), .mem_addr(mem_addr2),
        .mem_rdata(mem_rdata2), .redir_valid(1'b0), .redir_pc(8'h00),
        .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instr_data(instr_data2),
        .instr_pc(instr_pc2), .misalign_err(misalign_err2)
    );

    // Memory models: data returned exactly one cycle after the read request
    always @(posedge clk) begin
        mem_rdata  <= mem_rd  ? mem[mem_addr]  : 8'h00;
        mem_rdata2 <= mem_rd2 ? mem[mem_addr2] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges, checks during reset, then leaves the bench in cycle 0
    task automatic do_reset();
        nreset      = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 8'h00;
        next_cycle();
        next_cycle();
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_data", instr_data, 32'h0);
        check("rst_pc", 32'(instr_pc), 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);
        nreset = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (!instr_valid && n < max_cyc) begin
            next_cycle();
            n++;
        end
        check("wait_valid", 32'(instr_valid), 32'h1);
    endtask

    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_err;
    int          reads;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
        nreset2      = 1'b0;
        instr_ready2 = 1'b1;
        instr_ready  = 1'b1;

        // Streaming fetch with decode always ready
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) next_cycle();
            if (k <= 8) begin
                check($sformatf("A_rd_c%0d", k), 32'(mem_rd), 32'h1);
                check($sformatf("A_addr_c%0d", k), 32'(mem_addr), 32'(k));
            end
            if (k == 4 || k == 8) check($sformatf("A_valid_c%0d", k), 32'(instr_valid), 32'h0);
            if (k == 5) begin
                check("A_valid_c5", 32'(instr_valid), 32'h1);
                check("A_data_c5", instr_data, 32'h44332211);
                check("A_pc_c5", 32'(instr_pc), 32'h00);
            end
            if (k == 9) begin
                check("A_valid_c9", 32'(instr_valid), 32'h1);
                check("A_data_c9", instr_data, 32'h88776655);
                check("A_pc_c9", 32'(instr_pc), 32'h04);
            end
        end

        // Backpressure: FIFO fills, reads stop, head stays stable
        do_reset();
        instr_ready = 1'b0;
        reads = 0;
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) next_cycle();
            if (mem_rd) reads++;
            if (k == 10) check("B_head_c10", instr_data, 32'h44332211);
        end
        check("B_reads", 32'(reads), 32'd16);
        check("B_rd_stalled", 32'(mem_rd), 32'h0);
        check("B_head_data", instr_data, 32'h44332211);
        check("B_head_pc", 32'(instr_pc), 32'h00);
        instr_ready = 1'b1;
        next_cycle();
        instr_ready = 1'b0;
        #1;
        check("B_resume_rd", 32'(mem_rd), 32'h1);
        check("B_resume_addr", 32'(mem_addr), 32'h10);
        check("B_next_head", instr_data, 32'h88776655);
        check("B_next_pc", 32'(instr_pc), 32'h04);

        // Redirect while byte 2 of the instruction at 0x08 is outstanding
        do_reset();
        instr_ready = 1'b0;
        for (int k = 1; k <= 11; k++) next_cycle();
        redir_valid = 1'b1;
        redir_pc    = 8'h40;
        #1;
        check("C_redir_rd", 32'(mem_rd), 32'h0);
        check("C_pre_valid", 32'(instr_valid), 32'h1);
        next_cycle();
        redir_valid = 1'b0;
        #1;
        check("C_flush_valid", 32'(instr_valid), 32'h0);
        check("C_new_rd", 32'(mem_rd), 32'h1);
        check("C_new_addr", 32'(mem_addr), 32'h40);
        instr_ready = 1'b1;
        wait_valid(20);
        check("C_pc", 32'(instr_pc), 32'h40);
        check("C_data", instr_data, 32'h43424140);

        // Misaligned redirect
`ifdef IFETCH_ALIGN_CHECK_EN
        exp_addr = 8'h40; exp_data = 32'h43424140; exp_err = 1'b1;
`else
        exp_addr = 8'h42; exp_data = 32'h45444342; exp_err = 1'b0;
`endif
        do_reset();
        instr_ready = 1'b1;
        next_cycle();
        next_cycle();
        redir_valid = 1'b1;
        redir_pc    = 8'h42;
        #1;
        check("D_redir_rd", 32'(mem_rd), 32'h0);
        next_cycle();
        redir_valid = 1'b0;
        #1;
        check("D_addr", 32'(mem_addr), 32'(exp_addr));
        check("D_err", 32'(misalign_err), 32'(exp_err));
        wait_valid(20);
        check("D_pc", 32'(instr_pc), 32'(exp_addr));
        check("D_data", instr_data, exp_data);
        next_cycle();
        next_cycle();
        check("D_err_sticky", 32'(misalign_err), 32'(exp_err));

        // Reset pulse in the middle of an instruction
        do_reset();
        instr_ready = 1'b0;
        for (int k = 1; k <= 6; k++) next_cycle();
        nreset = 1'b0;
        #1;
        check("E_rst_rd", 32'(mem_rd), 32'h0);
        check("E_rst_valid", 32'(instr_valid), 32'h0);
        check("E_rst_data", instr_data, 32'h0);
        next_cycle();
        nreset = 1'b1;
        #1;
        check("E_valid_c0", 32'(instr_valid), 32'h0);
        check("E_rd_c0", 32'(mem_rd), 32'h1);
        check("E_addr_c0", 32'(mem_addr), 32'h00);
        instr_ready = 1'b1;
        wait_valid(20);
        check("E_pc", 32'(instr_pc), 32'h00);
        check("E_data", instr_data, 32'h44332211);

        // RESET_PC=8'hFC instance: address wrap
        nreset2 = 1'b1;
        #1;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) next_cycle();
            if (k <= 4) begin
                exp_addr = 8'hFC + 8'(k);
                check($sformatf("F_addr_c%0d", k), 32'(mem_addr2), 32'(exp_addr));
                check($sformatf("F_rd_c%0d", k), 32'(mem_rd2), 32'h1);
            end
            if (k == 5) begin
                check("F_valid_c5", 32'(instr_valid2), 32'h1);
                check("F_pc_c5", 32'(instr_pc2), 32'hFC);
                check("F_data_c5", instr_data2, 32'hFFFEFDFC);
            end
            if (k == 9) begin
                check("F_valid_c9", 32'(instr_valid2), 32'h1);
                check("F_pc_c9", 32'(instr_pc2), 32'h00);
                check("F_data_c9", instr_data2, 32'h44332211);
            end
        end
        check("F_misalign", 32'(misalign_err2), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, instruction FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter: RESET_PC, 8'h00, first fetch address after reset.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: nreset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port: mem_rd  output  1  byte read request to unified memory.
REQ-006 SHALL have port: mem_addr  output  8  byte address of the read.
REQ-007 SHALL have port: mem_rdata  input  8  read data, valid exactly one cycle after mem_rd.
REQ-008 SHALL have port: redir_valid  input  1  branch/jump redirect from execute.
REQ-009 SHALL have port: redir_pc  input  8  redirect target.
REQ-010 SHALL have port: instr_valid  output  1  FIFO head holds an instruction.
REQ-011 SHALL have port: instr_ready  input  1  decode accepts head.
REQ-012 SHALL have port: instr_data  output  32  head instruction word.
REQ-013 SHALL have port: instr_pc  output  8  byte address of head instruction.
REQ-014 SHALL have port: misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-015 SHALL build each instruction from 4 consecutive bytes, little-endian (byte at pc -> bits [7:0]).
REQ-016 SHALL drive mem_rd/mem_addr combinationally from registered fetch state; fetch_pc increments by 1 per issued read, wrapping 8'hFF -> 8'h00.
REQ-017 SHALL track one outstanding read via a pending bit; mem_rdata SHALL be captured only when pending is set.
REQ-018 SHALL start a new instruction (byte 0 read) only when FIFO count plus in-progress assembly is < DEPTH; a started instruction SHALL always complete (bytes 1-3 issued back-to-back).
REQ-019 SHALL push the assembled word and its start pc into the FIFO at the edge ending the cycle that byte 3 arrives; sustained throughput 1 instruction per 4 cycles.
REQ-020 SHALL present FIFO head on instr_data/instr_pc while instr_valid=1; pop on instr_valid & instr_ready; simultaneous push and pop SHALL keep count unchanged.
REQ-021 SHALL hold instr_data/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-022 SHALL, on redir_valid=1: flush FIFO, discard assembly, clear pending, set fetch_pc to redir_pc, assert no mem_rd that cycle; redirect overrides push and pop in the same cycle.
REQ-023 SHALL issue the first read at the new target the cycle after redirect; the stale byte returning then SHALL be discarded.
REQ-024 SHALL, when FIFO full with no pop, stop issuing byte-0 reads (mem_rd=0) and resume the cycle after a pop frees space.

Reset
REQ-025 SHALL, while nreset=0 at a rising edge: fetch_pc=RESET_PC, FIFO empty, assembly cleared, pending=0, misalign_err=0.
REQ-026 SHALL hold mem_rd=0, instr_valid=0, instr_data=0, instr_pc=0 during reset cycles.
REQ-027 SHALL, if reset asserts mid-instruction, abandon it; the first cycle with nreset=1 (cycle 0) SHALL issue mem_rd at RESET_PC.

Configuration
REQ-028 SHALL honour macro IFETCH_ALIGN_CHECK_EN: when defined, a redirect with redir_pc[1:0]!=0 SHALL set misalign_err (sticky until reset) and use {redir_pc[7:2],2'b00} as target.
REQ-029 SHALL, without IFETCH_ALIGN_CHECK_EN, use redir_pc unmodified and tie misalign_err to 0.

Verification
REQ-030 SHALL cover: memory bytes 0..7 = 11,22,33,44,55,66,77,88, instr_ready=1 -> instr_valid in cycle 5 with 32'h44332211/pc 0x00, then 32'h88776655/pc 0x04 in cycle 9.
REQ-031 SHALL cover: instr_ready=0, DEPTH=4 -> exactly 16 reads, mem_rd=0 thereafter, head 32'h44332211 stable; one pop -> byte-0 read at 0x10 the next cycle.
REQ-032 SHALL cover: redirect to 0x40 while byte 2 of pc 0x08 pending -> instr_valid drops next cycle, next mem_addr 0x40, first delivered instr_pc=0x40 with no stale bytes.
REQ-033 SHALL cover: RESET_PC=8'hFC -> addresses FC,FD,FE,FF,00; second instruction instr_pc=0x00.
REQ-034 SHALL cover: redirect to 0x42 -> with IFETCH_ALIGN_CHECK_EN fetch from 0x40 and misalign_err=1 until reset; without it fetch from 0x42, misalign_err=0.
REQ-035 SHALL cover: nreset=0 for one cycle mid-instruction -> FIFO empty, next mem_addr=RESET_PC, no partial word delivered.
